// File: rtl/ghost_csr_bank_pkg.sv
// rtl/ghost_csr_bank_pkg.sv - shared address offsets and parameter limits for the CSR bank
package ghost_csr_pkg;

  // Fixed register offsets, word addressed relative to the block base
  localparam int FLAGS_ADDR  = 'h10;
  localparam int SNAP_ADDR   = 'h11;
  localparam int MASK_ADDR   = 'h12;
  localparam int SHADOW_BASE = 'h20;

  // Legal parameter ranges; the address map assumes these hold
  localparam int NREG_MIN     = 1;
  localparam int NREG_MAX     = 16;
  localparam int NCH_MIN      = 1;
  localparam int NCH_MAX      = 16;
  localparam int RAM_BASE_MIN = 'h40;

endpackage

// File: rtl/ghost_csr_bank_if.sv
// rtl/ghost_csr_bank_if.sv - GhostBus host port bundle with host and bank views
interface ghost_csr_bank_if #(
  parameter int AW = 24,
  parameter int DW = 32
);

  logic [AW-1:0] gb_addr;
  logic [DW-1:0] gb_wdata;
  logic          gb_we;
  logic          gb_re;
  logic [DW-1:0] gb_rdata;
  logic          gb_rvalid;

  modport master (
    output gb_addr, gb_wdata, gb_we, gb_re,
    input  gb_rdata, gb_rvalid
  );

  modport slave (
    input  gb_addr, gb_wdata, gb_we, gb_re,
    output gb_rdata, gb_rvalid
  );

endinterface

// File: rtl/ghost_csr_bank_evt_counter.sv
// rtl/ghost_csr_bank_evt_counter.sv - one saturating event counter with clear and saturation pulse
module ghost_evt_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          evt,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          sat_set
);

  localparam logic [CW-1:0] MAX = '1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear wins over increment, but an event in the clear cycle is still counted
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = evt ? CW'(1) : '0;
    end else if (evt && (count_q != MAX)) begin
      count_d = count_q + CW'(1);
    end
  end

  // Pulse only on the increment that lands on the maximum, not while parked there
  assign sat_set = evt && (count_d == MAX) && (clr || (count_q != MAX));
  assign count   = count_q;

  // Counter state register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ghost_csr_bank.sv
// rtl/ghost_csr_bank.sv - control regs, snapshot counters, W1C flags with irq, and RAM window
module ghost_csr_bank
  import ghost_csr_pkg::*;
#(
  parameter int            AW        = 24,
  parameter int            DW        = 32,
  parameter int            NREG      = 4,
  parameter logic [DW-1:0] RESET_VAL = '0,
  parameter int            NCH       = 4,
  parameter int            CW        = 16,
  parameter int            RAM_AW    = 3,
  parameter int            RAM_DW    = 4,
  parameter int            RAM_BASE  = 'h40
) (
  input  logic                 clk,
  input  logic                 rst,
  ghost_csr_bank_if.slave      gb,
  output logic [NREG*DW-1:0]   ctrl_out,
  input  logic [NCH-1:0]       evt_in,
  output logic                 irq
);

  localparam logic [AW-1:0]        A_FLAGS = AW'(FLAGS_ADDR);
  localparam logic [AW-1:0]        A_SNAP  = AW'(SNAP_ADDR);
  localparam logic [AW-1:0]        A_MASK  = AW'(MASK_ADDR);
  localparam logic [AW-RAM_AW-1:0] RAM_TAG = (AW-RAM_AW)'(RAM_BASE >> RAM_AW);

  logic [DW-1:0]     ctrl_q   [NREG];
  logic [NCH-1:0]    flags_q;
  logic [NCH-1:0]    mask_q;
  logic [CW-1:0]     shadow_q [NCH];
  logic [CW-1:0]     count    [NCH];
  logic [NCH-1:0]    sat_vec;
  logic [RAM_DW-1:0] mem      [2**RAM_AW];

  logic [DW-1:0]     rdata_q;
  logic              rvalid_q;
  logic              irq_q;
  logic [DW-1:0]     rd_val;

  logic              is_ram;
  logic [RAM_AW-1:0] ram_idx;
  logic              snap_we;
  logic              snap_clr;
  logic [NCH-1:0]    w1c;

  assign is_ram   = (gb.gb_addr[AW-1:RAM_AW] == RAM_TAG);
  assign ram_idx  = gb.gb_addr[RAM_AW-1:0];
  assign snap_we  = gb.gb_we && (gb.gb_addr == A_SNAP);
  assign snap_clr = snap_we && gb.gb_wdata[0];
  assign w1c      = (gb.gb_we && (gb.gb_addr == A_FLAGS)) ? gb.gb_wdata[NCH-1:0] : '0;

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    ghost_evt_counter #(.CW(CW)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .evt     (evt_in[ch]),
      .clr     (snap_clr),
      .count   (count[ch]),
      .sat_set (sat_vec[ch])
    );
  end

  for (genvar i = 0; i < NREG; i++) begin : g_ctrl_out
    assign ctrl_out[i*DW +: DW] = ctrl_q[i];
  end

  // Read mux over current state, so a same-cycle write is not yet visible to the read
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NREG; i++) begin
      if (gb.gb_addr == AW'(i)) rd_val = ctrl_q[i];
    end
    if (gb.gb_addr == A_FLAGS) rd_val = DW'(flags_q);
    if (gb.gb_addr == A_MASK)  rd_val = DW'(mask_q);
    for (int ch = 0; ch < NCH; ch++) begin
      if (gb.gb_addr == AW'(SHADOW_BASE + ch)) rd_val = DW'(shadow_q[ch]);
    end
    if (is_ram) rd_val = DW'(mem[ram_idx]);
  end

  // Control register writes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) ctrl_q[i] <= RESET_VAL;
    end else if (gb.gb_we) begin
      for (int i = 0; i < NREG; i++) begin
        if (gb.gb_addr == AW'(i)) ctrl_q[i] <= gb.gb_wdata;
      end
    end
  end

  // Sticky flags: saturation sets override a same-cycle write-one-to-clear
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
      mask_q  <= '0;
    end else begin
      flags_q <= (flags_q & ~w1c) | sat_vec;
      if (gb.gb_we && (gb.gb_addr == A_MASK)) mask_q <= gb.gb_wdata[NCH-1:0];
    end
  end

  // Snapshot copies every counter in the same edge so the host sees a coherent set
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < NCH; ch++) shadow_q[ch] <= '0;
    end else if (snap_we) begin
      for (int ch = 0; ch < NCH; ch++) shadow_q[ch] <= count[ch];
    end
  end

  // RAM window write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (gb.gb_we && is_ram) mem[ram_idx] <= gb.gb_wdata[RAM_DW-1:0];
  end

  // Registered read response and interrupt; rdata holds between responses
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      rvalid_q <= gb.gb_re;
      if (gb.gb_re) rdata_q <= rd_val;
      irq_q <= |(flags_q & mask_q);
    end
  end

  assign gb.gb_rdata  = rdata_q;
  assign gb.gb_rvalid = rvalid_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_ghost_csr_bank.sv
// tb/tb_ghost_csr_bank.sv - directed scoreboard bench for the CSR bank
module tb_ghost_csr_bank;
  import ghost_csr_pkg::*;

  localparam int            AW       = 24;
  localparam int            DW       = 32;
  localparam int            NREG     = 4;
  localparam int            NCH      = 4;
  localparam int            CW       = 4;
  localparam int            RAM_AW   = 3;
  localparam int            RAM_DW   = 4;
  localparam int            RAM_BASE = 'h40;
  localparam logic [DW-1:0] RV       = 32'hA5A5_0001;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NCH-1:0]      evt_in = '0;
  logic [NREG*DW-1:0]  ctrl_out;
  logic                irq;

  ghost_csr_bank_if #(.AW(AW), .DW(DW)) gb ();

  ghost_csr_bank #(
    .AW(AW), .DW(DW), .NREG(NREG), .RESET_VAL(RV), .NCH(NCH), .CW(CW),
    .RAM_AW(RAM_AW), .RAM_DW(RAM_DW), .RAM_BASE(RAM_BASE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .gb       (gb),
    .ctrl_out (ctrl_out),
    .evt_in   (evt_in),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] val;
    string         tag;
  } exp_t;

  exp_t sb[$];
  exp_t sb_head;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  task automatic check(input logic [DW-1:0] obs, input logic [DW-1:0] exp, input string tag);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Response side of the scoreboard: every rvalid must match the oldest pending read
  always @(negedge clk) begin
    if (gb.gb_rvalid !== 1'b0) begin
      if (sb.size() == 0) begin
        check(32'(gb.gb_rvalid), 32'h0, "unexpected_rvalid");
      end else begin
        sb_head = sb.pop_front();
        check(gb.gb_rdata, sb_head.val, sb_head.tag);
      end
    end
  end

  task automatic cyc(input logic we, input logic re, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wdata, input logic [NCH-1:0] evt,
                     input logic [DW-1:0] exp, input string tag);
    gb.gb_we    = we;
    gb.gb_re    = re;
    gb.gb_addr  = addr;
    gb.gb_wdata = wdata;
    evt_in      = evt;
    if (re && !rst) sb.push_back('{val: exp, tag: tag});
    @(posedge clk);
    #1;
    gb.gb_we = 1'b0;
    gb.gb_re = 1'b0;
    evt_in   = '0;
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    cyc(1'b1, 1'b0, addr, wdata, '0, '0, "");
  endtask

  task automatic rd(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input string tag);
    cyc(1'b0, 1'b1, addr, '0, '0, exp, tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, '0, '0, '0, "");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    gb.gb_addr  = '0;
    gb.gb_wdata = '0;
    gb.gb_we    = 1'b0;
    gb.gb_re    = 1'b0;

    // Reset state
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    check(32'(gb.gb_rvalid), 32'h0, "reset_rvalid");
    check(gb.gb_rdata, 32'h0, "reset_rdata");
    check(32'(irq), 32'h0, "reset_irq");
    for (int i = 0; i < NREG; i++) check(ctrl_out[i*DW +: DW], RV, $sformatf("reset_ctrl_out%0d", i));
    for (int i = 0; i < NREG; i++) rd(AW'(i), RV, $sformatf("reset_rd_ctrl%0d", i));
    idle(2);

    // Write reg 2 with a same-cycle read, then read again
    cyc(1'b1, 1'b1, 24'd2, 32'hDEAD_BEEF, '0, RV, "rd_during_wr_old");
    check(ctrl_out[2*DW +: DW], 32'hDEAD_BEEF, "ctrl_out2_after_wr");
    rd(24'd2, 32'hDEAD_BEEF, "rd_after_wr");
    idle(1);
    check(gb.gb_rdata, 32'hDEAD_BEEF, "rdata_hold");
    check(32'(gb.gb_rvalid), 32'h0, "rvalid_single_pulse");

    // Counter 1 saturation and snapshot with clear plus coincident event
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, '0, '0, 4'b0010, '0, "");
    rd(AW'(FLAGS_ADDR), 32'h2, "flags_after_sat");
    check(32'(irq), 32'h0, "irq_masked");
    cyc(1'b1, 1'b0, AW'(SNAP_ADDR), 32'h1, 4'b0010, '0, "");
    rd(AW'(SHADOW_BASE + 1), 32'hF, "shadow1_saturated");
    rd(AW'(SHADOW_BASE), 32'h0, "shadow0_zero");
    rd(AW'(SNAP_ADDR), 32'h0, "snap_reads_zero");
    wr(AW'(SNAP_ADDR), 32'h0);
    rd(AW'(SHADOW_BASE + 1), 32'h1, "shadow1_after_clr_evt");

    // Mask, irq timing, W1C racing a fresh saturation, clean W1C
    wr(AW'(MASK_ADDR), 32'h2);
    check(32'(irq), 32'h0, "irq_lag_after_mask");
    idle(1);
    check(32'(irq), 32'h1, "irq_after_mask");
    rd(AW'(MASK_ADDR), 32'h2, "mask_readback");
    for (int i = 0; i < 13; i++) cyc(1'b0, 1'b0, '0, '0, 4'b0010, '0, "");
    cyc(1'b1, 1'b0, AW'(FLAGS_ADDR), 32'h2, 4'b0010, '0, "");
    rd(AW'(FLAGS_ADDR), 32'h2, "flag_sat_beats_w1c");
    check(32'(irq), 32'h1, "irq_held_on_race");
    wr(AW'(FLAGS_ADDR), 32'h2);
    check(32'(irq), 32'h1, "irq_lag_after_w1c");
    idle(1);
    check(32'(irq), 32'h0, "irq_cleared");
    rd(AW'(FLAGS_ADDR), 32'h0, "flags_cleared");

    // RAM window: upper write bits dropped, back-to-back reads, unmapped reads
    for (int k = 0; k < 8; k++) wr(AW'(RAM_BASE + k), 32'hFFFF_FFF0 | 32'(k ^ 5));
    for (int k = 0; k < 8; k++) rd(AW'(RAM_BASE + k), 32'(k ^ 5), $sformatf("ram_rd%0d", k));
    rd(24'h30, 32'h0, "unmapped_30");
    wr(24'h30, 32'h1234_5678);
    rd(24'h30, 32'h0, "unmapped_30_after_wr");
    rd(24'h13, 32'h0, "unmapped_13");
    rd(AW'(RAM_BASE + 8), 32'h0, "past_ram_end");

    // Load state, then reset across a read strobe
    wr(24'd0, 32'h1234_5678);
    wr(AW'(MASK_ADDR), 32'hF);
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, '0, '0, 4'b0001, '0, "");
    idle(1);
    check(32'(irq), 32'h1, "irq_before_reset");
    rst = 1'b1;
    rd(24'd0, 32'h0, "");
    rst = 1'b0;
    check(32'(gb.gb_rvalid), 32'h0, "no_rvalid_on_reset_read");
    check(gb.gb_rdata, 32'h0, "rdata_reset_midread");
    check(32'(irq), 32'h0, "irq_reset_midread");
    check(ctrl_out[0 +: DW], RV, "ctrl0_reset_midread");
    rd(24'd0, RV, "ctrl0_rd_after_reset");
    rd(AW'(MASK_ADDR), 32'h0, "mask_after_reset");
    rd(AW'(FLAGS_ADDR), 32'h0, "flags_after_reset");
    rd(AW'(SHADOW_BASE + 1), 32'h0, "shadow1_after_reset");
    wr(AW'(SNAP_ADDR), 32'h0);
    rd(AW'(SHADOW_BASE), 32'h0, "counter0_after_reset");
    for (int k = 0; k < 8; k++) rd(AW'(RAM_BASE + k), 32'(k ^ 5), $sformatf("ram_retained%0d", k));

    idle(3);
    check(32'(sb.size()), 32'h0, "scoreboard_drained");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ghost_csr_bank.md
# ghost_csr_bank

Parametrised host-accessible register bank for the GhostBus fabric: NREG control registers, NCH saturating event counters with atomic snapshot, sticky W1C status flags with masked interrupt, and a synchronous RAM window. Sits below a GhostBus-decoded module instance. Replaces hand-annotated per-module registers and RAMs with one block that has registered read-back and counter state the bus can sample coherently.

## Interface
- AW, 24, GhostBus address width (word addressed, relative to block base)
- DW, 32, GhostBus data width
- NREG, 4, number of R/W control registers (1..16)
- RESET_VAL, 32'h0, reset value of every control register (low DW bits used)
- NCH, 4, number of event counter channels (1..16)
- CW, 16, counter width (1..DW)
- RAM_AW, 3, RAM address width (depth 2**RAM_AW)
- RAM_DW, 4, RAM data width (1..DW)
- RAM_BASE, 'h40, RAM window base (aligned to 2**RAM_AW, ≥ 'h40)
- clk  in  1  sole clock
- rst  in  1  reset, synchronous, active-high
- gb_addr  in  AW  relative word address
- gb_wdata  in  DW  write data
- gb_we  in  1  write strobe, one cycle per write
- gb_re  in  1  read strobe, one cycle per read
- gb_rdata  out  DW  read data, valid when gb_rvalid
- gb_rvalid  out  1  one-cycle pulse, one per accepted gb_re
- ctrl_out  out  NREG*DW  control registers, reg i at [i*DW +: DW]
- evt_in  in  NCH  event pulses, one count per high cycle
- irq  out  1  registered OR of (flags & mask)

## Operation
- Address map: 0..NREG-1 control R/W; 'h10 FLAGS (W1C, NCH bits); 'h11 SNAP (write-only, read 0); 'h12 MASK (R/W, NCH bits); 'h20+ch SHADOW[ch] (RO, zero-extended to DW); RAM_BASE+k RAM[k] (R/W, low RAM_DW bits, zero-extended on read).
- Unmapped address: write ignored, read returns 0 with gb_rvalid.
- Counter ch: increments when evt_in[ch]=1; saturates at 2**CW-1 (no wrap); sets FLAGS[ch] on the increment that reaches saturation.
- SNAP write: all NCH counters copied to SHADOW in the same edge (atomic). If wdata[0]=1, counters also cleared; an event in that same cycle makes the new count 1, not 0.
- FLAGS write: bits with wdata=1 cleared; a saturation set in the same cycle wins (flag stays 1).
- Write and read of same address in the same cycle: read returns the pre-write value.
- gb_we and gb_re to different addresses in the same cycle: both serviced.

## Timing
- Writes take effect at the clk edge where gb_we=1; ctrl_out reflects them the next cycle.
- Read latency exactly 1: gb_rdata/gb_rvalid registered, asserted the cycle after gb_re; back-to-back reads every cycle supported.
- gb_rdata holds its last value when gb_rvalid=0.
- RAM is synchronous read (1 cycle), same latency as registers; no extra wait.
- irq updates one cycle after the flag or mask change.
- Reset (any cycle, including mid-read): ctrl regs = RESET_VAL, counters/SHADOW/FLAGS/MASK = 0, gb_rdata = 0, gb_rvalid = 0, irq = 0. A read strobed the cycle rst is high produces no gb_rvalid. RAM contents are not reset.

## Structure
- Package ghost_csr_pkg: address offsets (FLAGS_ADDR 'h10, SNAP_ADDR 'h11, MASK_ADDR 'h12, SHADOW_BASE 'h20), parameter range limits.
- Sub-module ghost_evt_counter: one saturating counter with clear, event and saturation-flag output; instantiated NCH times via generate.
- Top holds decode, W1C logic, read mux register, RAM array.

## Test plan
- Reset, then read addr 0..NREG-1 -> each returns RESET_VAL one cycle after gb_re, gb_rvalid single pulse; ctrl_out all RESET_VAL.
- Write 'hDEADBEEF to reg 2, read same cycle then next -> first read old value, second 'hDEADBEEF; ctrl_out[2*DW +: DW] updates next cycle.
- CW=4: pulse evt_in[1] 20 times, SNAP wdata=1 with evt_in[1] high, read 'h21 -> 15, FLAGS bit1=1, subsequent SNAP reads counter 1.
- MASK='h2, FLAGS bit1 set -> irq=1; write FLAGS 'h2 while saturation re-occurs same cycle -> flag stays 1; clean W1C -> irq=0 one cycle later.
- Write RAM[k]=k^'h5 for k=0..7 at RAM_BASE, read back-to-back -> values in order, one per cycle, upper DW-RAM_DW bits 0; read 'h30 -> 0.
- Assert rst during a read strobe after loading state -> no gb_rvalid, all registers at reset values, RAM contents retained.
